// File: rtl/hazard_ctrl.sv
// hazard_ctrl: bypass selects, load-use / MDU / debug stalls, exception flush
// and branch squash for the 5-stage core, plus a saturating stall counter.
// Stage vectors below are packed {if, id, exe, mem, wb}.
module hazard_ctrl #(
    parameter int REG_AW            = 5,
    parameter int MDU_LAT           = 4,
    parameter int CNT_W             = 16,
    parameter int BRANCH_DELAY_SLOT = 1,
    parameter int DEBUG_EN          = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_is_store,
    input  logic              id_is_mdu,
    input  logic              id_branch_taken,
    input  logic [REG_AW-1:0] exe_wb_addr,
    input  logic              exe_wb_wen,
    input  logic              exe_is_load,
    input  logic [REG_AW-1:0] mem_wb_addr,
    input  logic              mem_wb_wen,
    input  logic              mem_is_load,
    input  logic              exc_flush,
    output logic [1:0]        fwd_a_ctrl,
    output logic [1:0]        fwd_b_ctrl,
    output logic              fwd_m,
    output logic              if_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              if_rst,
    output logic              id_rst,
    output logic              exe_rst,
    output logic              mem_rst,
    output logic              wb_rst,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [MW-1:0] C_LOAD = MW'(MDU_LAT - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [MW-1:0]    r_cnt;
    logic             r_step_prev;
    logic             r_fwd_m;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_en, w_rst;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_hold, w_busy, w_load_stall, w_squash, w_store_fwd;
    logic       w_exe_ld, w_mdu_start, w_stall_evt;

    // Youngest writer wins: EXE result before MEM result; r0 is never bypassed.
    function automatic logic [1:0] f_fwd(
        input logic [REG_AW-1:0] a,
        input logic [REG_AW-1:0] ea, input logic ew,
        input logic [REG_AW-1:0] ma, input logic mw, input logic ml);
        if (a == '0)            return 2'b00;
        if (ew && ea == a)      return 2'b01;
        if (mw && ma == a)      return ml ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    assign w_fwd_a = f_fwd(id_rs_addr, exe_wb_addr, exe_wb_wen, mem_wb_addr, mem_wb_wen, mem_is_load);
    assign w_fwd_b = f_fwd(id_rt_addr, exe_wb_addr, exe_wb_wen, mem_wb_addr, mem_wb_wen, mem_is_load);

    // A load in EXE whose data is needed by the instruction in ID.
    assign w_exe_ld     = exe_wb_wen & exe_is_load & (exe_wb_addr != '0);
    assign w_load_stall = w_exe_ld & ((id_rs_used & (id_rs_addr == exe_wb_addr)) |
                                      (id_rt_used & (id_rt_addr == exe_wb_addr) & ~id_is_store));
    // Store data can wait one cycle and pick the load result off MEM instead.
    assign w_store_fwd  = w_exe_ld & id_is_store & (id_rt_addr == exe_wb_addr);

    assign w_hold   = (DEBUG_EN != 0) & debug_en & ~(debug_step & ~r_step_prev);
    assign w_busy   = (r_state == S_BUSY);
    assign w_squash = (BRANCH_DELAY_SLOT == 0) & id_branch_taken;

    // One stage-control action per cycle, highest priority first.
    always_comb begin
        w_en  = '1;
        w_rst = '0;
        if (rst)               w_rst = '1;
        else if (exc_flush)    w_rst = 5'b11110;
        else if (w_hold)       w_en  = '0;
        else if (w_busy) begin
            w_en  = 5'b00011;
            w_rst = 5'b00010;
        end else if (w_load_stall) begin
            w_en  = 5'b00111;
            w_rst = 5'b00100;
        end else if (w_squash) w_rst = 5'b01000;
    end

    assign {if_en, id_en, exe_en, mem_en, wb_en}      = w_en;
    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = w_rst;
    assign fwd_a_ctrl = rst ? 2'b00 : w_fwd_a;
    assign fwd_b_ctrl = rst ? 2'b00 : w_fwd_b;
    assign fwd_m      = r_fwd_m;
    assign mdu_busy   = w_busy;
    assign stall_cnt  = r_stall_cnt;

    assign w_mdu_start = (MDU_LAT > 1) & ~w_busy & w_en[3] & ~w_rst[3] & id_is_mdu;
    assign w_stall_evt = ~exc_flush & ~w_hold & (w_busy | w_load_stall);

    // Previous step level, for rising-edge detection of debug_step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_step_prev <= 1'b0;
        else     r_step_prev <= debug_step;
    end

    // Store-data bypass flag follows the instruction from ID into EXE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_fwd_m <= 1'b0;
        else if (exc_flush) r_fwd_m <= 1'b0;
        else if (w_en[2])   r_fwd_m <= w_store_fwd & ~w_rst[2];
    end

    // MDU hold: count down the extra EXE cycles of a multi-cycle op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (exc_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (!w_hold) begin
            if (w_busy) begin
                if (r_cnt == MW'(1)) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt - MW'(1);
                end
            end else if (w_mdu_start) begin
                r_state <= S_BUSY;
                r_cnt   <= C_LOAD;
            end
        end
    end

    // Saturating count of cycles lost to load-use or MDU stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_stall_cnt <= '0;
        else if (w_stall_evt && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    localparam int AW = 5, LAT = 4, CW = 5, BDS = 0, DBG = 1;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, debug_en, debug_step;
    logic [AW-1:0] id_rs_addr, id_rt_addr, exe_wb_addr, mem_wb_addr;
    logic id_rs_used, id_rt_used, id_is_store, id_is_mdu, id_branch_taken;
    logic exe_wb_wen, exe_is_load, mem_wb_wen, mem_is_load, exc_flush;
    logic [1:0] fwd_a_ctrl, fwd_b_ctrl;
    logic fwd_m, if_en, id_en, exe_en, mem_en, wb_en;
    logic if_rst, id_rst, exe_rst, mem_rst, wb_rst, mdu_busy;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(CW),
                  .BRANCH_DELAY_SLOT(BDS), .DEBUG_EN(DBG)) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_is_mdu(id_is_mdu),
        .id_branch_taken(id_branch_taken),
        .exe_wb_addr(exe_wb_addr), .exe_wb_wen(exe_wb_wen), .exe_is_load(exe_is_load),
        .mem_wb_addr(mem_wb_addr), .mem_wb_wen(mem_wb_wen), .mem_is_load(mem_is_load),
        .exc_flush(exc_flush), .fwd_a_ctrl(fwd_a_ctrl), .fwd_b_ctrl(fwd_b_ctrl),
        .fwd_m(fwd_m), .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en), .if_rst(if_rst), .id_rst(id_rst),
        .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // model state: remaining MDU hold cycles, pending store bypass, stall count, last step level
    int m_rem = 0, m_cnt = 0;
    bit m_fwdm = 0, m_sp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bypass source for a register: scan in-flight writers youngest first.
    function automatic logic [1:0] mfwd(input logic [AW-1:0] a);
        logic [AW-1:0] wa [2];
        bit            ww [2];
        wa[0] = exe_wb_addr; ww[0] = exe_wb_wen;
        wa[1] = mem_wb_addr; ww[1] = mem_wb_wen;
        if (a == 0) return 2'd0;
        for (int k = 0; k < 2; k++)
            if (ww[k] && wa[k] == a) return (k == 0) ? 2'd1 : (mem_is_load ? 2'd3 : 2'd2);
        return 2'd0;
    endfunction

    // Per-cycle reference check, then advance the model across the next edge.
    always @(negedge clk) begin
        logic [4:0] xen, xrst;
        logic [1:0] xa, xb;
        bit xm, xbusy, hold, ls, sq, ld;
        int xc;
        if (rst) begin
            xen = '1; xrst = '1; xa = 0; xb = 0; xm = 0; xbusy = 0; xc = 0;
            m_rem = 0; m_fwdm = 0; m_cnt = 0; m_sp = 0;
        end else begin
            ld   = exe_wb_wen && exe_is_load && exe_wb_addr != 0;
            hold = (DBG != 0) && debug_en && !(debug_step && !m_sp);
            ls   = ld && ((id_rs_used && id_rs_addr == exe_wb_addr) ||
                          (id_rt_used && id_rt_addr == exe_wb_addr && !id_is_store));
            sq   = id_branch_taken && BDS == 0;
            xa = mfwd(id_rs_addr); xb = mfwd(id_rt_addr);
            xm = m_fwdm; xbusy = (m_rem > 0); xc = m_cnt;
            xen = '1; xrst = '0;
            if (exc_flush) begin
                xrst = 5'b11110; m_rem = 0; m_fwdm = 0;
            end else if (hold) begin
                xen = '0;
            end else if (m_rem > 0) begin
                xen = 5'b00011; xrst = 5'b00010; m_rem--; m_cnt++;
            end else if (ls) begin
                xen = 5'b00111; xrst = 5'b00100; m_cnt++; m_fwdm = 0;
            end else begin
                if (sq) xrst = 5'b01000;
                m_fwdm = ld && id_is_store && id_rt_addr == exe_wb_addr;
                if (id_is_mdu && !sq && LAT > 1) m_rem = LAT - 1;
            end
            if (m_cnt > CMAX) m_cnt = CMAX;
            m_sp = debug_step;
        end
        chk("en",   {if_en, id_en, exe_en, mem_en, wb_en}, xen);
        chk("rst",  {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, xrst);
        chk("fwda", fwd_a_ctrl, xa);
        chk("fwdb", fwd_b_ctrl, xb);
        chk("fwdm", fwd_m, xm);
        chk("busy", mdu_busy, xbusy);
        chk("cnt",  stall_cnt, xc);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        debug_en = 0; debug_step = 0; exc_flush = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
        id_is_store = 0; id_is_mdu = 0; id_branch_taken = 0;
        exe_wb_addr = 0; exe_wb_wen = 0; exe_is_load = 0;
        mem_wb_addr = 0; mem_wb_wen = 0; mem_is_load = 0;
    endtask

    initial begin
        rst = 1; idle();
        #8;
        chk("r_rst",   {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b11111);
        chk("r_en",    {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        chk("r_cnt",   stall_cnt, 0);
        step(); rst = 0;
        // EXE ALU bypass, MEM load bypass, r0 never bypassed
        step(); exe_wb_addr = 3; exe_wb_wen = 1; id_rs_addr = 3; id_rs_used = 1;
        #3 chk("exe_fwd", fwd_a_ctrl, 2'b01); chk("exe_nostall", if_en, 1);
        step(); exe_wb_wen = 0; mem_wb_addr = 3; mem_wb_wen = 1; mem_is_load = 1;
        #3 chk("memld_fwd", fwd_a_ctrl, 2'b11);
        step(); idle(); exe_wb_wen = 1; id_rs_used = 1;
        #3 chk("r0_fwd", fwd_a_ctrl, 2'b00);
        // load-use stall, then load data bypassed from MEM
        step(); idle(); exe_wb_addr = 5; exe_wb_wen = 1; exe_is_load = 1;
        id_rt_addr = 5; id_rt_used = 1;
        #3 chk("ls_ifen", {if_en, id_en, exe_rst}, 3'b001); chk("ls_cnt0", stall_cnt, 0);
        step(); exe_wb_wen = 0; exe_is_load = 0; mem_wb_addr = 5; mem_wb_wen = 1; mem_is_load = 1;
        #3 chk("ls_cnt1", stall_cnt, 1); chk("ls_fwdb", fwd_b_ctrl, 2'b11);
        // store data from load: no stall, bypass flag one cycle later
        step(); idle(); exe_wb_addr = 5; exe_wb_wen = 1; exe_is_load = 1;
        id_rt_addr = 5; id_rt_used = 1; id_is_store = 1;
        #3 chk("st_nostall", {if_en, id_en}, 2'b11);
        step(); idle();
        #3 chk("st_fwdm", fwd_m, 1);
        // MDU hold of LAT-1 cycles
        step(); id_is_mdu = 1;
        #3 chk("mdu_issue", mdu_busy, 0);
        for (int i = 0; i < LAT - 1; i++) begin
            step(); id_is_mdu = 0;
            #3 chk("mdu_hold", {mdu_busy, if_en, id_en, exe_en, mem_rst}, 5'b10001);
        end
        step();
        #3 chk("mdu_done", mdu_busy, 0); chk("mdu_cnt", stall_cnt, 4);
        // exception flush during MDU hold
        step(); id_is_mdu = 1;
        step(); id_is_mdu = 0;
        step(); exc_flush = 1;
        #3 chk("flush_rst", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b11110);
        chk("flush_en", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        step(); exc_flush = 0;
        #3 chk("flush_idle", mdu_busy, 0); chk("flush_cnt", stall_cnt, 5);
        // debug hold and single step
        step(); debug_en = 1;
        #3 chk("dbg_hold", {if_en, wb_en}, 2'b00);
        step(); debug_step = 1;
        #3 chk("dbg_step", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b11111);
        step();
        #3 chk("dbg_held", {if_en, mem_en}, 2'b00);
        step(); debug_step = 0;
        #3 chk("dbg_held2", if_en, 0);
        step(); debug_en = 0;
        // branch squash, and load stall outranking it
        step(); id_branch_taken = 1;
        #3 chk("sq", id_rst, 1);
        step(); exe_wb_addr = 5; exe_wb_wen = 1; exe_is_load = 1; id_rt_addr = 5; id_rt_used = 1;
        #3 chk("sq_vs_ls", {id_rst, exe_rst}, 2'b01);
        // async reset in the middle of an MDU hold
        step(); idle(); id_is_mdu = 1;
        step(); id_is_mdu = 0;
        #2 rst = 1;
        #1 chk("arst_busy", mdu_busy, 0); chk("arst_cnt", stall_cnt, 0);
        chk("arst_rst", {if_rst, wb_rst, if_en}, 3'b111);
        step(); rst = 0;
        step();
        #3 chk("arst_idle", mdu_busy, 0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step();
            rst = ($urandom_range(0, 39) == 0);
            exc_flush = ($urandom_range(0, 15) == 0);
            debug_en = ($urandom_range(0, 5) == 0);
            debug_step = 1'($urandom);
            id_rs_addr = AW'($urandom_range(0, 3)); id_rt_addr = AW'($urandom_range(0, 3));
            exe_wb_addr = AW'($urandom_range(0, 3)); mem_wb_addr = AW'($urandom_range(0, 3));
            id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
            id_is_store = ($urandom_range(0, 3) == 0); id_is_mdu = ($urandom_range(0, 9) == 0);
            id_branch_taken = ($urandom_range(0, 5) == 0);
            exe_wb_wen = 1'($urandom); exe_is_load = 1'($urandom);
            mem_wb_wen = 1'($urandom); mem_is_load = 1'($urandom);
        end
        // counter saturation under a sustained load stall
        step(); idle(); rst = 1;
        step(); rst = 0; exe_wb_addr = 5; exe_wb_wen = 1; exe_is_load = 1;
        id_rs_addr = 5; id_rs_used = 1;
        for (int i = 0; i < CMAX + 8; i++) step();
        #3 chk("sat_cnt", stall_cnt, CMAX);
        step(); idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
